// File: rtl/multicore_pkg.sv
// Shared constants and types for the multicore data memory.
package multicore_pkg;

    localparam int unsigned NUM_CORES   = 4;
    localparam int unsigned REGION_SIZE = 64;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 8;

    typedef logic [1:0]        core_id_t;
    typedef logic [ADDR_W-1:0] mem_addr_t;
    typedef logic [DATA_W-1:0] mem_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping mod N.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] rr_ptr,
    output logic            grant_valid,
    output logic [IdxW-1:0] grant_idx
);

    int unsigned j;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(rr_ptr) + i) % N;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/data_memory_write_arbiter.sv
// Collects one posted byte write per core, relocates it into the core's region and
// drains the slots onto the single memory write port in round-robin order.
module data_memory_write_arbiter
    import multicore_pkg::*;
#(
    parameter int unsigned NUM_CORES   = multicore_pkg::NUM_CORES,
    parameter int unsigned ADDR_W      = multicore_pkg::ADDR_W,
    parameter int unsigned DATA_W      = multicore_pkg::DATA_W,
    parameter int unsigned REGION_SIZE = multicore_pkg::REGION_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          wr_valid,
    output logic [NUM_CORES-1:0]          wr_ready,
    input  logic [NUM_CORES*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wr_data,
    output logic [NUM_CORES-1:0]          wr_done,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_waddr,
    output logic [DATA_W-1:0]             mem_wdata,
    output core_id_t                      mem_wcore
);

    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0]             pending_q, pending_d;
    logic [NUM_CORES-1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [NUM_CORES-1:0][DATA_W-1:0] slot_data_q, slot_data_d;
    logic [IdxW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic                             mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]                mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0]                mem_wdata_q, mem_wdata_d;
    core_id_t                         mem_wcore_q, mem_wcore_d;
    logic [NUM_CORES-1:0]             wr_done_q, wr_done_d;

    logic [NUM_CORES-1:0] accept;
    logic                 grant_valid;
    logic [IdxW-1:0]      grant_idx;

    // Ready depends only on slot state, so a slot drained this edge reopens next cycle.
    assign wr_ready = ~pending_q & {NUM_CORES{~reset}};
    assign accept   = wr_valid & ~pending_q;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_rr_arbiter (
        .req         (pending_q),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        pending_d   = pending_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        rr_ptr_d    = rr_ptr_q;
        mem_we_d    = 1'b0;
        wr_done_d   = '0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wcore_d = mem_wcore_q;

        if (grant_valid) begin
            pending_d[grant_idx] = 1'b0;
            mem_we_d             = 1'b1;
            wr_done_d[grant_idx] = 1'b1;
            mem_waddr_d          = slot_addr_q[grant_idx];
            mem_wdata_d          = slot_data_q[grant_idx];
            mem_wcore_d          = core_id_t'(grant_idx);
            rr_ptr_d             = IdxW'((32'(grant_idx) + 1) % NUM_CORES);
        end

        // Accepted slots are never pending, so they cannot collide with the grant above.
        for (int unsigned n = 0; n < NUM_CORES; n++) begin
            if (accept[n]) begin
                pending_d[n]   = 1'b1;
                slot_addr_d[n] = wr_addr[n*ADDR_W +: ADDR_W] + ADDR_W'(n * REGION_SIZE);
                slot_data_d[n] = wr_data[n*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            rr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            wr_done_q   <= '0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_wcore_q <= '0;
        end else begin
            pending_q   <= pending_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_we_q    <= mem_we_d;
            wr_done_q   <= wr_done_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wcore_q <= mem_wcore_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign wr_done   = wr_done_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wcore = mem_wcore_q;

endmodule

// File: tb/tb_data_memory_write_arbiter.sv
// Directed bench for data_memory_write_arbiter with an in-order scoreboard of memory writes.
module tb_data_memory_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  wr_valid;
    logic [3:0]  wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_done;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [1:0]  mem_wcore;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic [1:0] core;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    data_memory_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wcore (mem_wcore)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and checked against the queue.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_waddr", 32'(mem_waddr), 32'(e.addr));
                chk("sb_wdata", 32'(mem_wdata), 32'(e.data));
                chk("sb_wcore", 32'(mem_wcore), 32'(e.core));
                chk("sb_done", 32'(wr_done), 32'(4'b0001 << e.core));
            end
        end else begin
            chk("idle_done", 32'(wr_done), 32'd0);
        end
    endtask

    task automatic drive(input int core, input logic [7:0] a, input logic [7:0] d);
        wr_valid[core]      = 1'b1;
        wr_addr[core*8 +: 8] = a;
        wr_data[core*8 +: 8] = d;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d, input logic [1:0] c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.core = c;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = '0;
        wr_addr  = '0;
        wr_data  = '0;

        // Reset state
        step();
        step();
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wcore", 32'(mem_wcore), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(wr_ready), 32'hF);

        // All four cores at once: drained 0..3 on consecutive cycles
        for (int n = 0; n < 4; n++) begin
            drive(n, 8'd0, 8'(n));
            push(8'(n * 64), 8'(n), 2'(n));
        end
        step();
        wr_valid = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("all_we", 32'(mem_we), 32'd1);
        end
        chk("all_drained", 32'(sb.size()), 32'd0);

        // Single write from core 2
        drive(2, 8'd5, 8'hAA);
        push(8'd133, 8'hAA, 2'd2);
        chk("single_ready_pre", 32'(wr_ready[2]), 32'd1);
        step();
        wr_valid = '0;
        chk("single_ready_low", 32'(wr_ready[2]), 32'd0);
        chk("single_no_we_yet", 32'(mem_we), 32'd0);
        step();
        chk("single_we", 32'(mem_we), 32'd1);
        chk("single_waddr", 32'(mem_waddr), 32'd133);
        chk("single_ready_back", 32'(wr_ready[2]), 32'd1);

        // Address wrap-around
        drive(3, 8'd200, 8'h11);
        push(8'd136, 8'h11, 2'd3);
        step();
        wr_valid = '0;
        step();
        chk("wrap_c3", 32'(mem_waddr), 32'd136);
        drive(0, 8'd255, 8'h22);
        push(8'd255, 8'h22, 2'd0);
        step();
        wr_valid = '0;
        step();
        chk("wrap_c0", 32'(mem_waddr), 32'd255);

        // Idle: enables low, address/data hold
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_we", 32'(mem_we), 32'd0);
            chk("idle_waddr", 32'(mem_waddr), 32'd255);
            chk("idle_wdata", 32'(mem_wdata), 32'h22);
        end

        // Reset with cores 1 and 3 captured but not issued
        drive(1, 8'd7, 8'h33);
        drive(3, 8'd9, 8'h44);
        step();
        wr_valid = '0;
        reset    = 1'b1;
        #1;
        chk("midrst_ready", 32'(wr_ready), 32'd0);
        step();
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_waddr", 32'(mem_waddr), 32'd0);
        chk("midrst_wdata", 32'(mem_wdata), 32'd0);
        chk("midrst_wcore", 32'(mem_wcore), 32'd0);
        chk("midrst_done", 32'(wr_done), 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(wr_ready), 32'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_discard", 32'(mem_we), 32'd0);
        end

        // Fairness: cores 0 and 1 held valid for 20 cycles; grants start at core 0
        drive(0, 8'd10, 8'h50);
        drive(1, 8'd10, 8'h51);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) push(8'd10, 8'h50, 2'd0);
            else            push(8'd74, 8'h51, 2'd1);
        end
        for (int i = 0; i <= 20; i++) begin
            step();
            if (i >= 1) chk("fair_we", 32'(mem_we), 32'd1);
            if (i == 19) wr_valid = '0;
        end
        wait_drain(8);
        step();
        chk("fair_end_we", 32'(mem_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
